// File: rtl/lane_packer_if.sv
// Handshake bundle for lane_packer: element stream in, packed lane word out.
// The packer is the slave side; whatever drives elements and takes words is the master.
interface lane_packer_if #(
    parameter int ELEM_WIDTH = 20,
    parameter int ELEM_NUM   = 10
);
    localparam int CW = $clog2(ELEM_NUM + 1);

    logic                                 i_valid;
    logic                                 o_ready;
    logic [ELEM_WIDTH-1:0]                i_data;
    logic                                 i_last;
    logic                                 o_valid;
    logic                                 i_ready;
    logic [ELEM_NUM-1:0][ELEM_WIDTH-1:0]  o_data;
    logic [CW-1:0]                        o_count;

    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_data, o_count
    );

    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_data, o_count
    );
endinterface

// File: rtl/lane_packer.sv
// lane_packer: gathers ELEM_NUM serial elements into one packed [lane][bit] word.
// FILL accepts one element per cycle; FULL presents the word until downstream takes it.
// i_last closes a partial word early; lanes never written in that word stay zero.
module lane_packer #(
    parameter int ELEM_WIDTH = 20,
    parameter int ELEM_NUM   = 10,
    parameter int MSB_FIRST  = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    lane_packer_if.slave  bus
);
    localparam int CW = $clog2(ELEM_NUM + 1);
    localparam int KW = $clog2(ELEM_NUM);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                               state_q, state_d;
    logic [KW-1:0]                        k_q, k_d;
    logic [ELEM_NUM-1:0][ELEM_WIDTH-1:0]  buf_q, buf_d;
    logic [CW-1:0]                        count_q, count_d;
    logic [KW-1:0]                        lane;

    // Map the running element index onto the lane it fills.
    always_comb begin
        lane = k_q;
        if (MSB_FIRST != 0) begin
            lane = KW'(ELEM_NUM - 1) - k_q;
        end
    end

    // Next-state logic: write lanes while filling, freeze in FULL, clear on handoff.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        buf_d   = buf_q;
        count_d = count_q;
        case (state_q)
            FILL: begin
                if (bus.i_valid) begin
                    buf_d[lane] = bus.i_data;
                    if ((k_q == KW'(ELEM_NUM - 1)) || bus.i_last) begin
                        state_d = FULL;
                        count_d = CW'(k_q) + CW'(1);
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            FULL: begin
                if (bus.i_ready) begin
                    state_d = FILL;
                    buf_d   = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State, index, word buffer and count registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= FILL;
            k_q     <= '0;
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

    assign bus.o_ready = (state_q == FILL);
    assign bus.o_valid = (state_q == FULL);
    assign bus.o_data  = buf_q;
    assign bus.o_count = count_q;
endmodule

// File: tb/tb_lane_packer.sv
// Bench for lane_packer: one MSB-first and one LSB-first instance share the same stimulus.
// Expected words are queued at the accept of their closing element and compared while presented.
module tb_lane_packer;
    localparam int W = 20;
    localparam int N = 10;

    typedef logic [N-1:0][W-1:0] word_t;
    typedef struct {
        word_t      word;
        logic [3:0] count;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          valid;
    logic          last;
    logic          ready;
    logic [W-1:0]  data;

    int            n_checks;
    int            n_fails;

    exp_t          exp_q_m[$];
    exp_t          exp_q_l[$];
    bit            m_full;
    int            m_k;
    word_t         m_word_m;
    word_t         m_word_l;

    lane_packer_if #(.ELEM_WIDTH(W), .ELEM_NUM(N)) bus_m ();
    lane_packer_if #(.ELEM_WIDTH(W), .ELEM_NUM(N)) bus_l ();

    assign bus_m.i_valid = valid;
    assign bus_m.i_data  = data;
    assign bus_m.i_last  = last;
    assign bus_m.i_ready = ready;
    assign bus_l.i_valid = valid;
    assign bus_l.i_data  = data;
    assign bus_l.i_last  = last;
    assign bus_l.i_ready = ready;

    lane_packer #(.ELEM_WIDTH(W), .ELEM_NUM(N), .MSB_FIRST(1)) dut_m (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_m)
    );

    lane_packer #(.ELEM_WIDTH(W), .ELEM_NUM(N), .MSB_FIRST(0)) dut_l (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_l)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q_m.delete();
        exp_q_l.delete();
        m_full   = 1'b0;
        m_k      = 0;
        m_word_m = '0;
        m_word_l = '0;
    endtask

    task automatic model_update(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        exp_t e;
        if (!m_full) begin
            if (v) begin
                m_word_m[N-1-m_k] = d;
                m_word_l[m_k]     = d;
                if ((m_k == N - 1) || l) begin
                    e.count = 4'(m_k + 1);
                    e.word  = m_word_m;
                    exp_q_m.push_back(e);
                    e.word  = m_word_l;
                    exp_q_l.push_back(e);
                    m_full   = 1'b1;
                    m_k      = 0;
                    m_word_m = '0;
                    m_word_l = '0;
                end else begin
                    m_k++;
                end
            end
        end else if (r) begin
            void'(exp_q_m.pop_front());
            void'(exp_q_l.pop_front());
            m_full = 1'b0;
        end
    endtask

    task automatic check_output();
        check("ready_m", 256'(bus_m.o_ready), 256'(!m_full));
        check("valid_m", 256'(bus_m.o_valid), 256'(m_full));
        check("ready_l", 256'(bus_l.o_ready), 256'(!m_full));
        check("valid_l", 256'(bus_l.o_valid), 256'(m_full));
        if (m_full) begin
            if (exp_q_m.size() == 0 || exp_q_l.size() == 0) begin
                check("scoreboard_empty", 256'(1), 256'(0));
            end else begin
                check("data_m",  256'(bus_m.o_data),  256'(exp_q_m[0].word));
                check("count_m", 256'(bus_m.o_count), 256'(exp_q_m[0].count));
                check("data_l",  256'(bus_l.o_data),  256'(exp_q_l[0].word));
                check("count_l", 256'(bus_l.o_count), 256'(exp_q_l[0].count));
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid_m"}, 256'(bus_m.o_valid), 256'(0));
        check({tag, "_ready_m"}, 256'(bus_m.o_ready), 256'(1));
        check({tag, "_data_m"},  256'(bus_m.o_data),  256'(0));
        check({tag, "_count_m"}, 256'(bus_m.o_count), 256'(0));
        check({tag, "_valid_l"}, 256'(bus_l.o_valid), 256'(0));
        check({tag, "_data_l"},  256'(bus_l.o_data),  256'(0));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check at the falling edge.
    task automatic apply_stimulus(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        valid = v;
        data  = d;
        last  = l;
        ready = r;
        @(posedge clk);
        model_update(v, d, l, r);
        @(negedge clk);
        check_output();
    endtask

    // Directed sequence covering fills, flushes, backpressure and asynchronous reset.
    initial begin
        n_checks = 0;
        n_fails  = 0;
        model_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        data  = '0;
        last  = 1'b0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Full word 1..10 on both lane orders.
        for (int i = 1; i <= N; i++) apply_stimulus(1'b1, W'(i), 1'b0, 1'b1);
        check("full_m_lane9", 256'(bus_m.o_data[9]), 256'(1));
        check("full_m_lane0", 256'(bus_m.o_data[0]), 256'(10));
        check("full_m_count", 256'(bus_m.o_count), 256'(10));
        check("full_l_lane0", 256'(bus_l.o_data[0]), 256'(1));
        check("full_l_lane9", 256'(bus_l.o_data[9]), 256'(10));
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check("full_valid_drop", 256'(bus_m.o_valid), 256'(0));

        // Early flush after three elements.
        apply_stimulus(1'b1, 20'hABCDE, 1'b0, 1'b1);
        apply_stimulus(1'b1, 20'h12345, 1'b0, 1'b1);
        apply_stimulus(1'b1, 20'h0000F, 1'b1, 1'b1);
        check("flush_lane9", 256'(bus_m.o_data[9]), 256'(20'hABCDE));
        check("flush_lane8", 256'(bus_m.o_data[8]), 256'(20'h12345));
        check("flush_lane7", 256'(bus_m.o_data[7]), 256'(20'h0000F));
        check("flush_low_lanes", 256'(bus_m.o_data[6:0]), 256'(0));
        check("flush_count", 256'(bus_m.o_count), 256'(3));
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);

        // Backpressure: hold the word for five cycles while the input side churns.
        for (int i = 1; i <= N; i++) apply_stimulus(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            check("bp_ready_low", 256'(bus_m.o_ready), 256'(0));
            check("bp_lane9_hold", 256'(bus_m.o_data[9]), 256'(20'h00101));
            check("bp_lane0_hold", 256'(bus_m.o_data[0]), 256'(20'h0010A));
        end
        apply_stimulus(1'b1, 20'h00777, 1'b0, 1'b1);
        check("bp_released", 256'(bus_m.o_data), 256'(0));

        // i_last on the first element of a fresh word.
        apply_stimulus(1'b1, 20'h00555, 1'b1, 1'b1);
        check("last1_count", 256'(bus_m.o_count), 256'(1));
        check("last1_lane9", 256'(bus_m.o_data[9]), 256'(20'h00555));
        check("last1_others", 256'(bus_m.o_data[8:0]), 256'(0));
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);

        // i_last on the tenth element yields exactly one full word.
        for (int i = 1; i <= N; i++) apply_stimulus(1'b1, W'(32'h300 + i), (i == N), 1'b1);
        check("last10_count", 256'(bus_m.o_count), 256'(10));
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check("last10_no_extra", 256'(bus_m.o_valid), 256'(0));

        // Asynchronous reset in the middle of a word.
        for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, W'(32'h400 + i), 1'b0, 1'b1);
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 1; i <= N; i++) apply_stimulus(1'b1, W'(32'h200 + i), 1'b0, 1'b1);
        check("postreset_lane9", 256'(bus_m.o_data[9]), 256'(20'h00201));
        check("postreset_lane0", 256'(bus_m.o_data[0]), 256'(20'h0020A));
        check("postreset_count", 256'(bus_m.o_count), 256'(10));
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
